// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and sequencer states.
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_CALC = 2'b01;
    localparam logic [1:0] S_ADJ  = 2'b10;

endpackage

// File: rtl/mdu_iter_dp.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring-divide step.
module mdu_iter_dp #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
        w_shl  = {i_hi, i_lo[WIDTH-1]};
        w_diff = w_shl - {1'b0, i_b};
        o_hi   = '0;
        o_lo   = '0;
        if (i_div) begin
            // Borrow clear means the trial subtraction fits: keep it and shift in a 1.
            if (!w_diff[WIDTH]) begin
                o_hi = w_diff[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi = w_shl[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/pipe_mdu_ctrl.sv
// Iterative multiply/divide sequencer holding architectural HI/LO and the ID-stage stall.
module pipe_mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             id_start,
    input  logic [1:0]       id_op,
    input  logic [WIDTH-1:0] id_a,
    input  logic [WIDTH-1:0] id_b,
    input  logic             id_rd_hi,
    input  logic             id_rd_lo,
    input  logic             id_wr_hi,
    input  logic             id_wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             mdu_wpcir
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_div_op;
    logic             w_use_sgn;
    logic             w_accept;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_dp_hi;
    logic [WIDTH-1:0] w_dp_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign busy      = (r_state != S_IDLE);
    assign mdu_wpcir = ~(busy & (id_start | id_rd_hi | id_rd_lo));
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign done      = r_done;

    // Divide by zero runs unsigned on the raw operands so HI ends up holding a unchanged.
    assign w_div_op  = (id_op == MDU_DIV) || (id_op == MDU_DIVU);
    assign w_use_sgn = ((id_op == MDU_MULT) || (id_op == MDU_DIV)) && !(w_div_op && (id_b == '0));
    assign w_abs_a   = (w_use_sgn && id_a[WIDTH-1]) ? -id_a : id_a;
    assign w_abs_b   = (w_use_sgn && id_b[WIDTH-1]) ? -id_b : id_b;
    assign w_accept  = (r_state == S_IDLE) && id_start && mdu_wpcir;

    mdu_iter_dp #(.WIDTH(WIDTH)) u_dp (
        .i_div (r_div),
        .i_hi  (r_acc),
        .i_lo  (r_q),
        .i_b   (r_b),
        .o_hi  (w_dp_hi),
        .o_lo  (w_dp_lo)
    );

    always_comb begin
        w_prod   = r_neg_q ? -{r_acc, r_q} : {r_acc, r_q};
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_div) begin
            w_res_lo = r_neg_q ? -r_q : r_q;
            w_res_hi = r_neg_r ? -r_acc : r_acc;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_b     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (id_wr_hi) r_hi <= wr_data;
                    if (id_wr_lo) r_lo <= wr_data;
                    if (w_accept) begin
                        r_state <= S_CALC;
                        r_cnt   <= CNT_LOAD;
                        r_div   <= w_div_op;
                        r_neg_q <= w_use_sgn & (id_a[WIDTH-1] ^ id_b[WIDTH-1]);
                        r_neg_r <= w_use_sgn & w_div_op & id_a[WIDTH-1];
                        r_acc   <= '0;
                        r_q     <= w_abs_a;
                        r_b     <= w_abs_b;
                    end
                end
                S_CALC: begin
                    r_acc <= w_dp_hi;
                    r_q   <= w_dp_lo;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == '0) r_state <= S_ADJ;
                end
                S_ADJ: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // mthi/mtlo arriving while an operation runs are dropped; flag it in simulation.
    a_no_wr_busy: assert property (@(posedge clock) disable iff (!resetn)
        !(busy && (id_wr_hi || id_wr_lo)))
        else $error("mthi/mtlo dropped while MDU busy");

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Scoreboard bench for pipe_mdu_ctrl: directed mult/div vectors, stalls, mthi/mtlo, reset abort.
module tb_pipe_mdu_ctrl;
    import mdu_pkg::*;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             resetn;
    logic             id_start, id_rd_hi, id_rd_lo, id_wr_hi, id_wr_lo;
    logic [1:0]       id_op;
    logic [WIDTH-1:0] id_a, id_b, wr_data;
    logic [WIDTH-1:0] hi, lo;
    logic             busy, done, mdu_wpcir;

    typedef struct {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;

    pipe_mdu_ctrl #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .id_start  (id_start),
        .id_op     (id_op),
        .id_a      (id_a),
        .id_b      (id_b),
        .id_rd_hi  (id_rd_hi),
        .id_rd_lo  (id_rd_lo),
        .id_wr_hi  (id_wr_hi),
        .id_wr_lo  (id_wr_lo),
        .wr_data   (wr_data),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .mdu_wpcir (mdu_wpcir)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clock) begin
        if (resetn) begin
            if (done) begin
                chk("done_pulse_width", 64'(prev_done), 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(sb.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result_hi", 64'(hi), 64'(e.hi));
                    chk("result_lo", 64'(lo), 64'(e.lo));
                    chk("done_cycle", 64'(cyc), 64'(e.due));
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Present a start (caller is at a falling edge); hold it until accepted.
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] ehi, input logic [WIDTH-1:0] elo, output int stalls);
        id_op = op; id_a = a; id_b = b; id_start = 1'b1;
        stalls = 0;
        #1;
        while (!mdu_wpcir && stalls < 200) begin
            @(negedge clock); #1;
            stalls++;
        end
        if (!mdu_wpcir) chk("start_accept_timeout", 64'(mdu_wpcir), 64'd1);
        sb.push_back('{hi: ehi, lo: elo, due: cyc + WIDTH + 2});
        @(negedge clock);
        id_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] ehi, input logic [WIDTH-1:0] elo);
        int st;
        issue(op, a, b, ehi, elo, st);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, st;
        resetn = 1'b0; id_start = 1'b0; id_op = 2'b00; id_a = '0; id_b = '0;
        id_rd_hi = 1'b0; id_rd_lo = 1'b0; id_wr_hi = 1'b0; id_wr_lo = 1'b0; wr_data = '0;
        repeat (2) @(negedge clock);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_wpcir", 64'(mdu_wpcir), 64'd1);
        resetn = 1'b1;

        // mthi / mtlo while idle
        @(negedge clock); id_wr_hi = 1'b1; wr_data = 32'h1234_5678;
        @(negedge clock); id_wr_hi = 1'b0;
        chk("mthi", 64'(hi), 64'h1234_5678);
        id_wr_lo = 1'b1; wr_data = 32'h9ABC_DEF0;
        @(negedge clock); id_wr_lo = 1'b0;
        chk("mtlo", 64'(lo), 64'h9ABC_DEF0);
        chk("mtlo_keeps_hi", 64'(hi), 64'h1234_5678);

        // multu max*max, with busy duration measured
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, st);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("busy_cycles", 64'(n), 64'(WIDTH + 1));
        @(negedge clock);

        run_op(MDU_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op(MDU_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001);
        run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op(MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
        run_op(MDU_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op(MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // mtlo in the same cycle as an accepted start: lands, later overwritten
        id_wr_lo = 1'b1; wr_data = 32'hAAAA_5555;
        issue(MDU_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, st);
        id_wr_lo = 1'b0;
        chk("mtlo_with_start", 64'(lo), 64'hAAAA_5555);
        wait_idle();

        // mfhi one cycle after start stalls until the result is valid
        issue(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, st);
        id_rd_hi = 1'b1;
        #1;
        n = 0;
        while (!mdu_wpcir && n < 100) begin
            n++;
            @(negedge clock); #1;
        end
        chk("mfhi_stall_cycles", 64'(n), 64'(WIDTH + 1));
        chk("mfhi_release_hi", 64'(hi), 64'd2);
        chk("mfhi_release_done", 64'(done), 64'd1);
        id_rd_hi = 1'b0;
        wait_idle();

        // back-to-back start: second is stalled, then accepted
        issue(MDU_MULTU, 32'd1000, 32'd1000, 32'd0, 32'd1000000, st);
        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF6, st);
        chk("b2b_stall_cycles", 64'(st), 64'(WIDTH + 1));
        wait_idle();

        // reset in CALC cycle 10 aborts the operation
        issue(MDU_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, st);
        repeat (9) @(negedge clock);
        resetn = 1'b0;
        #1;
        sb.delete();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clock); resetn = 1'b1;
        @(negedge clock);
        run_op(MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
